fifo: RTL and testbench
=======================

Name: fifo

Overview:
- Single-clock, synchronous first-in-first-out buffer with DEPTH entries of WIDTH bits each.
- Provides write/read enables, full/empty status flags and a registered read data port.
- Used as a generic rate/burst decoupling buffer between a producer and a consumer in the same clock domain.

Parameters:
- DEPTH, 128, number of entries; must be a power of two and at least 2.
- WIDTH, 32, data word width in bits.

Ports:
- i_clk  input  1  system clock; all state updates on its rising edge.
- arst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data, captured when a write is accepted.
- rd_en  input  1  read request.
- rd_data  output  WIDTH  registered read data.
- o_full  output  1  high when count == DEPTH.
- o_empty  output  1  high when count == 0.

Behaviour:
- Internal state:
  - wr_ptr, rd_ptr and count, each $clog2(DEPTH)+1 bits wide.
  - Storage array fifo_mem of DEPTH x WIDTH.
  - These internal names are kept so benches can probe them hierarchically.
- Reset (arst_n low, asynchronous):
  - wr_ptr, rd_ptr and count clear to 0.
  - rd_data clears to 0.
  - o_empty = 1, o_full = 0.
  - Memory contents are not cleared.
- Reset mid-operation discards all stored entries. Operation resumes on the first rising edge after arst_n deasserts.
- Write accept is wr_en && !o_full:
  - fifo_mem[wr_ptr low bits] <= wr_data.
  - wr_ptr increments by 1.
- Read accept is rd_en && !o_empty:
  - rd_data <= fifo_mem[rd_ptr low bits].
  - rd_ptr increments by 1.
  - Read latency is 1 cycle: data is valid after the accepting edge.
- rd_data holds its last value when no read is accepted.
- Write while full is ignored: no state change, data dropped. Read while empty is ignored: rd_data holds.
- Simultaneous accepted read and write:
  - Both pointers advance and count is unchanged.
  - When empty, the write is accepted and the read is rejected.
  - When full, the read is accepted and the write is rejected.
- count update per edge: +1 on write-only accept, -1 on read-only accept, otherwise unchanged.
- o_full and o_empty are combinational decodes of count. They reflect the new state in the cycle after the accepting edge.
- Pointers wrap naturally modulo 2*DEPTH. The MSB is an extra lap bit; addressing uses the low $clog2(DEPTH) bits.
- Data order is strict FIFO. There is no data corruption across wrap-around.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, the block adds two ports:
  - o_overflow  output 1: sticky, set on any edge with wr_en && o_full.
  - o_underflow  output 1: sticky, set on any edge with rd_en && o_empty.
  - Both clear only on reset.
- When undefined, these ports and their registers do not exist. Attempted overflow/underflow is silently ignored as described above.

Decomposition:
- Package fifo_pkg holds:
  - default DEPTH/WIDTH constants;
  - the address-width helper constant ADDR_W = $clog2(DEPTH);
  - the pointer typedef (ADDR_W+1 bits).
- Natural sub-module: fifo_ram.
  - Simple dual-port storage: one synchronous write port, one synchronous read port with registered output.
  - The top level keeps pointers, count, flags and accept logic.

Test Plan:
- Reset: hold arst_n low for 2 cycles -> o_empty=1, o_full=0, count=0, rd_data=0; release -> flags unchanged until the first write.
- Single word: write 32'hDEADBEEF, then one cycle later assert rd_en -> rd_data=32'hDEADBEEF one edge after the read; o_empty returns to 1.
- Fill: write 128 words 0..127 -> o_full=1 after the 128th write; a 129th write of 32'hFFFFFFFF is dropped (count stays 128); then read all 128 -> values 0..127 in order, then o_empty=1.
- Underflow: rd_en held high while empty for 3 cycles -> rd_data holds its previous value and count stays 0; with FIFO_ERR_FLAGS_EN, o_underflow=1.
- Simultaneous: with 5 entries stored, assert wr_en and rd_en together for 10 cycles -> count stays 5 and read data follows write order; with the FIFO full, assert both -> read accepted, write dropped, count 127.
- Random traffic: 50+ cycles with ~25% write and ~25% read probability, compared against a queue model -> zero mismatches, including pointer wrap after more than 128 total writes.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and pointer types for the fifo block.
// Pointers carry one extra lap bit above the address so full and empty stay distinguishable.
package fifo_pkg;

  localparam int DEF_DEPTH = 128;
  localparam int DEF_WIDTH = 32;
  localparam int ADDR_W    = $clog2(DEF_DEPTH);

  typedef logic [ADDR_W:0] ptr_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read into a registered output.
// Read data holds when no read is requested; the array itself is never reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             arst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] fifo_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) begin
      fifo_mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge i_clk or negedge arst_n) begin
    if (!arst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= fifo_mem[raddr];
    end
  end

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO, 1-cycle registered read; writes dropped when full, reads ignored when empty.
// Sticky o_overflow/o_underflow ports exist only when FIFO_ERR_FLAGS_EN is defined.
module fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             arst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             o_full,
  output logic             o_empty
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic             o_overflow,
  output logic             o_underflow
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] lptr_t;

  localparam lptr_t ONE      = lptr_t'(1);
  localparam lptr_t FULL_CNT = lptr_t'(DEPTH);

  lptr_t wr_ptr;
  lptr_t rd_ptr;
  lptr_t count;
  logic  wr_acc;
  logic  rd_acc;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign wr_acc  = wr_en && !o_full;
  assign rd_acc  = rd_en && !o_empty;

  always_ff @(posedge i_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .i_clk  (i_clk),
    .arst_n (arst_n),
    .we     (wr_acc),
    .waddr  (wr_ptr[AW-1:0]),
    .wdata  (wr_data),
    .re     (rd_acc),
    .raddr  (rd_ptr[AW-1:0]),
    .rdata  (rd_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  // Attempts are flagged even though the access itself is harmlessly dropped.
  always_ff @(posedge i_clk or negedge arst_n) begin
    if (!arst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= o_overflow  | (wr_en & o_full);
      o_underflow <= o_underflow | (rd_en & o_empty);
    end
  end
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: table of single-cycle vectors, hand-written corner sequences,
// and a queue-model random phase long enough to wrap the pointers.
module tb_fifo;

  localparam int DEPTH = 128;
  localparam int WIDTH = 32;

  logic             i_clk;
  logic             arst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             o_full;
  logic             o_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic             o_overflow;
  logic             o_underflow;
`endif

  int n_cmp;
  int n_err;

  fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .arst_n  (arst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .o_full  (o_full),
    .o_empty (o_empty)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic        exp_empty;
    logic        exp_full;
    logic [31:0] exp_rd_data;
    int          exp_count;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive for one edge, then settle past it before the caller samples.
  task automatic cycle(input logic wr, input logic [31:0] wd, input logic rd);
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    @(posedge i_clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  task automatic check_state(input string tag, input int cnt, input logic emp, input logic ful);
    check({tag, " count"}, 32'(dut.count), 32'(cnt));
    check({tag, " empty"}, 32'(o_empty), 32'(emp));
    check({tag, " full"},  32'(o_full),  32'(ful));
  endtask

  logic [31:0] model_q [$];
  logic [31:0] exp_rd;
  int          total_wr;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    arst_n   = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_data  = '0;
    total_wr = 0;

    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        1};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 0};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 0};
    vecs[3] = '{1'b1, 32'h11,       1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1};
    vecs[4] = '{1'b1, 32'h22,       1'b1, 1'b0, 1'b0, 32'h11,       1};
    vecs[5] = '{1'b1, 32'h33,       1'b0, 1'b0, 1'b0, 32'h11,       2};
    vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h22,       1};
    vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h33,       0};
    vecs[8] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h33,       0};

    // Reset held for two edges
    repeat (2) @(posedge i_clk);
    #1;
    check_state("reset", 0, 1'b1, 1'b0);
    check("reset rd_data", rd_data, 32'h0);
    arst_n = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    check_state("post-reset idle", 0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      cycle(vecs[i].wr, vecs[i].wdata, vecs[i].rd);
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd_data);
      check_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_empty, vecs[i].exp_full);
    end

    // Fill to DEPTH, then an extra write must be dropped
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 32'(i), 1'b0);
    end
    check_state("filled", DEPTH, 1'b0, 1'b1);
    cycle(1'b1, 32'hFFFFFFFF, 1'b0);
    check_state("overfill", DEPTH, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow flag", 32'(o_overflow), 32'h1);
`endif

    // Both at full: read wins, write dropped
    cycle(1'b1, 32'hAAAA5555, 1'b1);
    check("full rw rd_data", rd_data, 32'h0);
    check_state("full rw", DEPTH - 1, 1'b0, 1'b0);

    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check($sformatf("drain%0d", i), rd_data, 32'(i));
    end
    check_state("drained", 0, 1'b1, 1'b0);

    // Underflow attempts leave data and count untouched
    repeat (3) begin
      cycle(1'b0, 32'h0, 1'b1);
      check("underflow hold", rd_data, 32'd127);
      check("underflow count", 32'(dut.count), 32'h0);
    end
`ifdef FIFO_ERR_FLAGS_EN
    check("underflow flag", 32'(o_underflow), 32'h1);
`endif

    // Five stored, then ten cycles of simultaneous read and write
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'(100 + i), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'(105 + i), 1'b1);
      check($sformatf("simul%0d", i), rd_data, 32'(100 + i));
      check("simul count", 32'(dut.count), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check($sformatf("simul drain%0d", i), rd_data, 32'(110 + i));
    end
    check_state("simul drained", 0, 1'b1, 1'b0);

    // Random traffic against a queue model
    exp_rd = rd_data;
    for (int c = 0; c < 700; c++) begin
      logic        w, r;
      logic [31:0] d;
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      if (c >= 350 && c < 450) w = 1'b1;
      d = $urandom;
      if (r && model_q.size() > 0) exp_rd = model_q.pop_front();
      if (w && model_q.size() < DEPTH) begin
        model_q.push_back(d);
        total_wr++;
      end
      cycle(w, d, r);
      check($sformatf("rand%0d rd_data", c), rd_data, exp_rd);
      check_state($sformatf("rand%0d", c), model_q.size(),
                  model_q.size() == 0, model_q.size() == DEPTH);
    end
    if (total_wr <= DEPTH) begin
      n_err++;
      $display("FAIL random wrap coverage: got %0d writes expected more than %0d", total_wr, DEPTH);
    end

    // Asynchronous reset mid-operation, away from any clock edge
    cycle(1'b1, 32'h12345678, 1'b0);
    #2;
    arst_n = 1'b0;
    #1;
    check_state("mid reset", 0, 1'b1, 1'b0);
    check("mid reset rd_data", rd_data, 32'h0);
    @(posedge i_clk);
    #1;
    arst_n = 1'b1;
    cycle(1'b1, 32'hCAFEF00D, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("after reset rd_data", rd_data, 32'hCAFEF00D);
    check_state("after reset", 0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
